// File: rtl/ahbl_burst_master.sv
// AHB-Lite burst master: command port, write-data FIFO, INCR bursts with 1 KB re-NONSEQ and ERROR abort.
// Optional HREADY-low watchdog enabled by defining AHBL_MASTER_TIMEOUT_EN.
module ahbl_burst_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MAX_BEATS      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        SYSCLK,
    input  logic                        SYSRST,
    input  logic                        CMD_VALID,
    output logic                        CMD_READY,
    input  logic [ADDR_WIDTH-1:0]       CMD_ADDR,
    input  logic                        CMD_WRITE,
    input  logic [2:0]                  CMD_SIZE,
    input  logic [$clog2(MAX_BEATS):0]  CMD_BEATS,
    input  logic                        CMD_LOCK,
    input  logic                        WR_VALID,
    output logic                        WR_READY,
    input  logic [DATA_WIDTH-1:0]       WR_DATA,
    output logic                        RD_VALID,
    output logic [DATA_WIDTH-1:0]       RD_DATA,
    output logic                        RD_LAST,
    output logic                        DONE,
    output logic                        ERR,
    output logic [ADDR_WIDTH-1:0]       HADDR,
    output logic [1:0]                  HTRANS,
    output logic                        HWRITE,
    output logic [2:0]                  HSIZE,
    output logic [2:0]                  HBURST,
    output logic [3:0]                  HPROT,
    output logic                        HMASTLOCK,
    output logic [DATA_WIDTH-1:0]       HWDATA,
    input  logic [DATA_WIDTH-1:0]       HRDATA,
    input  logic                        HREADY,
    input  logic                        HRESP,
    output logic [2:0]                  dbg_state,
    output logic [$clog2(MAX_BEATS):0]  dbg_fifo_count
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // ready never depends on valid, and RD_VALID has no backpressure.
    localparam int PW = $clog2(MAX_BEATS);
    localparam int BW = PW + 1;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_DRAIN, S_ERROR} state_t;
    state_t state, state_n;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic [2:0]            burst_q;
    logic                  lock_q;
    logic [BW-1:0]         addr_left;
    logic                  dp_valid;
    logic                  dp_last;
    logic [DATA_WIDTH-1:0] hwdata_q;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_last_q;
    logic                  done_q;
    logic                  err_q;

    logic [DATA_WIDTH-1:0] mem [MAX_BEATS];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [BW-1:0]         fifo_count;
    logic [BW-1:0]         pop_n;
    logic                  push;

    logic [1:0] htrans_c;
    logic       addr_acc;
    logic       data_ok;
    logic       fin;
    logic       fin_err;
    logic       flush;
    logic       timeout;
    logic       size_bad;
    logic       cmd_acc;

    assign size_bad  = CMD_SIZE > MAX_SIZE;
    assign WR_READY  = fifo_count != BW'(MAX_BEATS);
    assign push      = WR_VALID && WR_READY;
    assign CMD_READY = !SYSRST && state == S_IDLE && !done_q &&
                       (!CMD_WRITE || fifo_count >= CMD_BEATS);
    assign cmd_acc   = CMD_VALID && CMD_READY;

`ifdef AHBL_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge SYSCLK) begin
        if (SYSRST || HREADY || state == S_IDLE || timeout) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign timeout = state != S_IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES);
`else
    logic unused_tmo;
    assign unused_tmo = TIMEOUT_CYCLES == 0;
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge SYSCLK) begin
        if (SYSRST) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        htrans_c = T_IDLE;
        addr_acc = 1'b0;
        data_ok  = 1'b0;
        fin      = 1'b0;
        fin_err  = 1'b0;
        flush    = 1'b0;
        case (state)
            S_IDLE:  if (cmd_acc && !size_bad) state_n = S_ADDR;
            S_ADDR:  htrans_c = T_NONSEQ;
            // Crossing a 1 KB page restarts the burst with NONSEQ.
            S_BURST: htrans_c = (addr_q[9:0] == 10'd0) ? T_NONSEQ : T_SEQ;
            S_ERROR: begin
                if (HREADY) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                    flush   = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: ;
        endcase
        if (state == S_ADDR || state == S_BURST || state == S_DRAIN) begin
            if (dp_valid && HRESP) begin
                htrans_c = T_IDLE;
                if (HREADY) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                    flush   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    state_n = S_ERROR;
                end
            end else if (HREADY) begin
                if (dp_valid) begin
                    data_ok = 1'b1;
                    if (dp_last) begin
                        fin     = 1'b1;
                        state_n = S_IDLE;
                    end
                end
                if (htrans_c != T_IDLE) begin
                    addr_acc = 1'b1;
                    state_n  = (addr_left == BW'(1)) ? S_DRAIN : S_BURST;
                end
            end
        end
        if (timeout) begin
            htrans_c = T_IDLE;
            addr_acc = 1'b0;
            data_ok  = 1'b0;
            fin      = 1'b1;
            fin_err  = 1'b1;
            flush    = 1'b1;
            state_n  = S_IDLE;
        end
    end

    // An aborted write discards every beat whose address phase was never accepted.
    always_comb begin
        pop_n = '0;
        if (write_q && addr_acc) begin
            pop_n = BW'(1);
        end else if (write_q && flush) begin
            pop_n = addr_left;
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (push) begin
            mem[wr_ptr] <= WR_DATA;
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (SYSRST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr     <= rd_ptr + pop_n[PW-1:0];
            fifo_count <= fifo_count + BW'(push) - pop_n;
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (SYSRST) begin
            addr_q     <= '0;
            write_q    <= 1'b0;
            size_q     <= '0;
            burst_q    <= '0;
            lock_q     <= 1'b0;
            addr_left  <= '0;
            dp_valid   <= 1'b0;
            dp_last    <= 1'b0;
            hwdata_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            if (cmd_acc) begin
                addr_q    <= CMD_ADDR;
                write_q   <= CMD_WRITE;
                size_q    <= CMD_SIZE;
                lock_q    <= CMD_LOCK;
                addr_left <= CMD_BEATS;
                burst_q   <= (CMD_BEATS == BW'(1)) ? 3'b000 : 3'b001;
                if (size_bad) begin
                    done_q <= 1'b1;
                    err_q  <= 1'b1;
                end
            end
            if (addr_acc) begin
                addr_q    <= addr_q + (ADDR_WIDTH'(1) << size_q);
                addr_left <= addr_left - 1'b1;
                dp_last   <= addr_left == BW'(1);
                if (write_q) begin
                    hwdata_q <= mem[rd_ptr];
                end
            end
            if (addr_acc) begin
                dp_valid <= 1'b1;
            end else if (data_ok || fin || cmd_acc) begin
                dp_valid <= 1'b0;
            end
            if (data_ok && !write_q) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= HRDATA;
                rd_last_q  <= dp_last;
            end
            if (fin) begin
                done_q <= 1'b1;
                err_q  <= fin_err;
            end
        end
    end

    assign HADDR          = addr_q;
    assign HTRANS         = htrans_c;
    assign HWRITE         = write_q;
    assign HSIZE          = size_q;
    assign HBURST         = burst_q;
    assign HPROT          = 4'b0011;
    assign HMASTLOCK      = lock_q && state != S_IDLE;
    assign HWDATA         = hwdata_q;
    assign RD_VALID       = rd_valid_q;
    assign RD_DATA        = rd_data_q;
    assign RD_LAST        = rd_last_q;
    assign DONE           = done_q;
    assign ERR            = err_q;
    assign dbg_state      = state;
    assign dbg_fifo_count = fifo_count;

endmodule

// File: tb/tb_ahbl_burst_master.sv
// Randomised bench for ahbl_burst_master: bench-side AHB slave, burst address model and write-data queue.
module tb_ahbl_burst_master;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MB = 16;

  logic          SYSCLK = 1'b0;
  logic          SYSRST = 1'b1;
  logic          CMD_VALID = 1'b0;
  logic          CMD_READY;
  logic [AW-1:0] CMD_ADDR = '0;
  logic          CMD_WRITE = 1'b0;
  logic [2:0]    CMD_SIZE = '0;
  logic [4:0]    CMD_BEATS = '0;
  logic          CMD_LOCK = 1'b0;
  logic          WR_VALID = 1'b0;
  logic          WR_READY;
  logic [DW-1:0] WR_DATA = '0;
  logic          RD_VALID;
  logic [DW-1:0] RD_DATA;
  logic          RD_LAST;
  logic          DONE;
  logic          ERR;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [2:0]    HBURST;
  logic [3:0]    HPROT;
  logic          HMASTLOCK;
  logic [DW-1:0] HWDATA;
  logic [DW-1:0] HRDATA = '0;
  logic          HREADY = 1'b1;
  logic          HRESP = 1'b0;
  logic [2:0]    dbg_state;
  logic [4:0]    dbg_fifo_count;

  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] wq[$];

  ahbl_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BEATS(MB), .TIMEOUT_CYCLES(8)) dut (
    .SYSCLK(SYSCLK), .SYSRST(SYSRST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_ADDR(CMD_ADDR), .CMD_WRITE(CMD_WRITE), .CMD_SIZE(CMD_SIZE), .CMD_BEATS(CMD_BEATS),
    .CMD_LOCK(CMD_LOCK), .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_DATA(WR_DATA),
    .RD_VALID(RD_VALID), .RD_DATA(RD_DATA), .RD_LAST(RD_LAST), .DONE(DONE), .ERR(ERR),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP), .dbg_state(dbg_state), .dbg_fifo_count(dbg_fifo_count)
  );

  // clock / watchdog
  always #5 SYSCLK = ~SYSCLK;

  initial begin
    #2000000;
    $display("FAIL global_watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rfunc(input logic [AW-1:0] a);
    return a * 32'h9E37_79B9 + 32'h1234_5677;
  endfunction

  // driver: one write-data push
  task automatic push(input logic [DW-1:0] d);
    logic exp_rdy;
    @(negedge SYSCLK);
    WR_VALID = 1'b1;
    WR_DATA  = d;
    #1;
    exp_rdy = wq.size() < MB;
    chk("wr_ready", WR_READY, exp_rdy);
    @(posedge SYSCLK);
    if (exp_rdy) wq.push_back(d);
    #1 WR_VALID = 1'b0;
  endtask

  // driver + slave + scoreboard for one command
  task automatic run_cmd(input logic wr, input logic [AW-1:0] addr, input logic [2:0] size,
                         input int beats, input logic lock, input int err_beat,
                         input int wait_beat, input int wait_n, input int max_wait);
    logic [DW-1:0] exp_wd[256];
    logic [AW-1:0] a_i;
    logic [AW-1:0] step;
    logic [1:0]    exp_tr;
    logic bad, dp_pend, exp_rv, exp_rl, exp_done, exp_err, first_err;
    logic [DW-1:0] exp_rd;
    int acc, dp_beat, dp_wait, stage, waits, done_cyc, n;
    bad  = size > 3'd2;
    step = 32'd1 << size;
    @(negedge SYSCLK);
    CMD_ADDR  = addr;
    CMD_WRITE = wr;
    CMD_SIZE  = size;
    CMD_BEATS = 5'(beats);
    CMD_LOCK  = lock;
    CMD_VALID = 1'b1;
    #1;
    chk("cmd_ready", CMD_READY, !wr || wq.size() >= beats);
    n = 0;
    while (!CMD_READY && n < 50) begin
      @(negedge SYSCLK);
      #1;
      n++;
    end
    if (!CMD_READY) begin
      chk("cmd_accept_bound", CMD_READY, 1'b1);
      CMD_VALID = 1'b0;
      return;
    end
    @(posedge SYSCLK);
    acc = 0; dp_pend = 0; dp_beat = 0; dp_wait = 0; stage = 0; waits = 0; done_cyc = -1;
    exp_rv = 0; exp_rl = 0; exp_rd = '0; exp_done = bad; exp_err = bad;
    for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
      @(negedge SYSCLK);
      CMD_VALID = 1'b0;
      CMD_WRITE = 1'b0;
      HREADY = 1'b1;
      HRESP  = 1'b0;
      first_err = 1'b0;
      if (dp_pend) begin
        if (dp_beat == err_beat && stage == 0) begin
          HREADY = 1'b0; HRESP = 1'b1; stage = 1; first_err = 1'b1;
        end else if (stage == 1) begin
          HRESP = 1'b1; stage = 2;
        end else if (dp_wait > 0) begin
          HREADY = 1'b0; dp_wait--; waits++;
        end else begin
          HRDATA = rfunc(addr + 32'(dp_beat) * step);
        end
      end
      #1;
      chk("rd_valid", RD_VALID, exp_rv);
      if (exp_rv) begin
        chk("rd_data", RD_DATA, exp_rd);
        chk("rd_last", RD_LAST, exp_rl);
      end
      chk("done", DONE, exp_done);
      if (exp_done) begin
        chk("err", ERR, exp_err);
        done_cyc = cyc;
      end
      chk("cmd_ready_busy", CMD_READY, 1'b0);
      if (first_err) chk("err_htrans_idle", HTRANS, 2'b00);
      exp_rv = 0; exp_done = 0; exp_err = 0;
      if (stage == 2) begin
        exp_done = 1; exp_err = 1; dp_pend = 0; stage = 3;
      end else if (dp_pend && HREADY) begin
        if (wr) begin
          chk("hwdata", HWDATA, exp_wd[dp_beat]);
        end else begin
          exp_rv = 1;
          exp_rd = rfunc(addr + 32'(dp_beat) * step);
          exp_rl = dp_beat == beats - 1;
        end
        if (dp_beat == beats - 1) exp_done = 1;
        dp_pend = 0;
      end
      if (HTRANS != 2'b00 && HREADY) begin
        chk("beat_count", !bad && acc < beats && stage == 0, 1'b1);
        a_i = addr + 32'(acc) * step;
        exp_tr = (acc == 0 || a_i[9:0] == 10'd0) ? 2'b10 : 2'b11;
        chk("haddr", HADDR, a_i);
        chk("htrans", HTRANS, exp_tr);
        chk("hsize", HSIZE, size);
        chk("hwrite", HWRITE, wr);
        chk("hburst", HBURST, (beats == 1) ? 3'b000 : 3'b001);
        chk("hmastlock", HMASTLOCK, lock);
        if (wr && acc < 256) exp_wd[acc] = (wq.size() > 0) ? wq.pop_front() : '0;
        dp_pend = 1;
        dp_beat = acc;
        dp_wait = (acc == wait_beat) ? wait_n : $urandom_range(max_wait, 0);
        acc++;
      end
    end
    HREADY = 1'b1;
    HRESP  = 1'b0;
    if (done_cyc < 0) chk("done_bound", 1'b0, 1'b1);
    else if (!bad && stage == 0) chk("latency", done_cyc, beats + 2 + waits);
    if (!bad && stage == 0) chk("beats_issued", acc, beats);
    if (wr && stage != 0) begin
      for (int i = acc; i < beats; i++) if (wq.size() > 0) void'(wq.pop_front());
    end
    chk("fifo_count", dbg_fifo_count, wq.size());
    @(negedge SYSCLK);
    #1;
    chk("ready_after_done", CMD_READY, 1'b1);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [2:0] rs;
    int rb, re;
    logic rw;
    // reset
    repeat (3) @(negedge SYSCLK);
    #1;
    chk("rst_cmd_ready", CMD_READY, 1'b0);
    SYSRST = 1'b0;
    @(negedge SYSCLK);
    #1;
    chk("rst_htrans", HTRANS, 2'b00);
    chk("rst_haddr", HADDR, '0);
    chk("rst_hburst", HBURST, 3'b000);
    chk("rst_hmastlock", HMASTLOCK, 1'b0);
    chk("rst_hwdata", HWDATA, '0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_rd_valid", RD_VALID, 1'b0);
    chk("rst_fifo", dbg_fifo_count, 5'd0);
    chk("rst_wr_ready", WR_READY, 1'b1);
    chk("hprot", HPROT, 4'b0011);

    // 4-beat write at 0x100, zero wait
    for (int i = 0; i < 4; i++) push(32'h1111_1111 * (i + 1));
    run_cmd(1'b1, 32'h100, 3'd2, 4, 1'b0, -1, -1, 0, 0);

    // 3-beat read across 0x400 with 2 waits on beat 2
    run_cmd(1'b0, 32'h3F8, 3'd2, 3, 1'b1, -1, 1, 2, 0);

    // 8-beat write, ERROR on beat 2
    for (int i = 0; i < 8; i++) push($urandom);
    run_cmd(1'b1, 32'h2000, 3'd2, 8, 1'b0, 1, -1, 0, 0);

    // illegal size
    run_cmd(1'b0, 32'h40, 3'd3, 4, 1'b0, -1, -1, 0, 0);

    // write needing 5 beats with only 4 buffered
    for (int i = 0; i < 4; i++) push($urandom);
    @(negedge SYSCLK);
    CMD_WRITE = 1'b1;
    CMD_BEATS = 5'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ready_short_fifo", CMD_READY, 1'b0);
      @(negedge SYSCLK);
    end
    push($urandom);
    @(negedge SYSCLK);
    #1;
    chk("ready_fifo_filled", CMD_READY, 1'b1);
    run_cmd(1'b1, 32'h500, 3'd2, 5, 1'b0, -1, -1, 0, 1);

    // full FIFO: 17th push refused, then a 16-beat write over 0x800
    for (int i = 0; i < MB + 1; i++) push($urandom);
    run_cmd(1'b1, 32'h7F0, 3'd2, 16, 1'b1, -1, -1, 0, 1);

    // reset in the middle of a burst
    for (int i = 0; i < 4; i++) push(32'hA5A5_0000 + i);
    @(negedge SYSCLK);
    CMD_ADDR = 32'h600; CMD_WRITE = 1'b1; CMD_SIZE = 3'd2; CMD_BEATS = 5'd4; CMD_LOCK = 1'b1;
    CMD_VALID = 1'b1;
    @(posedge SYSCLK);
    @(negedge SYSCLK);
    CMD_VALID = 1'b0;
    CMD_WRITE = 1'b0;
    @(negedge SYSCLK);
    #1;
    chk("pre_rst_htrans", HTRANS, 2'b11);
    SYSRST = 1'b1;
    HREADY = 1'b0;
    @(posedge SYSCLK);
    #1;
    chk("midrst_htrans", HTRANS, 2'b00);
    chk("midrst_haddr", HADDR, '0);
    chk("midrst_hwrite", HWRITE, 1'b0);
    chk("midrst_hmastlock", HMASTLOCK, 1'b0);
    chk("midrst_hwdata", HWDATA, '0);
    chk("midrst_fifo", dbg_fifo_count, 5'd0);
    chk("midrst_cmd_ready", CMD_READY, 1'b0);
    chk("midrst_done", DONE, 1'b0);
    @(negedge SYSCLK);
    SYSRST = 1'b0;
    HREADY = 1'b1;
    wq.delete();

    // random commands
    for (int k = 0; k < 25; k++) begin
      rw = 1'($urandom_range(1, 0));
      rs = 3'($urandom_range(2, 0));
      rb = $urandom_range(MB, 1);
      ra = (32'($urandom_range(15, 1)) << 10) - (32'($urandom_range(20, 0)) << rs);
      re = ($urandom_range(4, 0) == 0) ? $urandom_range(rb - 1, 0) : -1;
      if (rw) for (int i = 0; i < rb; i++) push($urandom);
      run_cmd(rw, ra, rs, rb, 1'($urandom_range(1, 0)), re, -1, 0, 2);
    end

`ifdef AHBL_MASTER_TIMEOUT_EN
    // HREADY stuck low: DONE/ERR nine cycles after it falls
    @(negedge SYSCLK);
    CMD_ADDR = 32'h0; CMD_WRITE = 1'b0; CMD_SIZE = 3'd2; CMD_BEATS = 5'd2; CMD_LOCK = 1'b0;
    CMD_VALID = 1'b1;
    @(posedge SYSCLK);
    @(negedge SYSCLK);
    CMD_VALID = 1'b0;
    begin
      int seen;
      seen = -1;
      for (int k = 0; k < 20 && seen < 0; k++) begin
        @(negedge SYSCLK);
        HREADY = 1'b0;
        #1;
        if (k == 8) chk("tmo_htrans_idle", HTRANS, 2'b00);
        if (DONE) begin
          seen = k;
          chk("tmo_err", ERR, 1'b1);
        end
      end
      chk("tmo_cycles", seen, 9);
    end
    @(negedge SYSCLK);
    HREADY = 1'b1;
`endif

    repeat (2) @(negedge SYSCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
